// File: rtl/io_responder.sv
// io_responder: KS-10 IO bus target serving a 4-word scratch/diagnostic window.
// Define IORESP_STATS_EN to make word 3 return the transaction counter.
module io_responder #(
  parameter logic [17:0] BASE_ADDR = 18'o200000,
  parameter int unsigned ACK_DELAY = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        clken,
  input  logic        busREQI,
  input  logic        busIO,
  input  logic        busWRITE,
  input  logic [17:0] busADDRI,
  input  logic [35:0] busDATAI,
  output logic        busACKO,
  output logic [35:0] busDATAO,
  output logic        busBUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  localparam logic [1:0] DLY = ACK_DELAY[1:0];

  state_t      state_q;
  logic        req_last_q;
  logic [1:0]  dly_q;
  logic [1:0]  word_q;
  logic        wr_q;
  logic [35:0] wdata_q;
  logic [35:0] reg_q [3];
  logic        ack_q;
  logic [35:0] dout_q;
`ifdef IORESP_STATS_EN
  logic [35:0] cnt_q;
`endif

  logic        hit;
  logic        start;
  logic        in_idle;
  logic        fire;
  logic        cur_wr;
  logic [1:0]  cur_word;
  logic [35:0] cur_data;
  logic [35:0] rdata_d;

  assign hit     = busADDRI[17:2] == BASE_ADDR[17:2];
  assign start   = busREQI & busIO & ~req_last_q & hit;
  assign in_idle = state_q == S_IDLE;

  // Zero-delay acks complete straight out of IDLE, so use live bus fields.
  assign cur_word = in_idle ? busADDRI[1:0] : word_q;
  assign cur_wr   = in_idle ? busWRITE : wr_q;
  assign cur_data = in_idle ? busDATAI : wdata_q;

  assign fire = in_idle
              ? (start & (DLY == 2'd0))
              : ((state_q == S_WAIT) & busREQI & (dly_q == 2'd1));

  always_comb begin
    rdata_d = '0;
    unique case (cur_word)
      2'd0: rdata_d = reg_q[0];
      2'd1: rdata_d = reg_q[1];
      2'd2: rdata_d = reg_q[2];
      2'd3: begin
`ifdef IORESP_STATS_EN
        rdata_d = cnt_q;
`else
        rdata_d = '0;
`endif
      end
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      req_last_q <= 1'b0;
      dly_q      <= '0;
      word_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      for (int i = 0; i < 3; i++) reg_q[i] <= '0;
`ifdef IORESP_STATS_EN
      cnt_q      <= '0;
`endif
    end else if (clken) begin
      req_last_q <= busREQI;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      if (in_idle && start) begin
        word_q  <= busADDRI[1:0];
        wr_q    <= busWRITE;
        wdata_q <= busDATAI;
        dly_q   <= DLY;
      end
      if (fire) begin
        state_q <= S_ACK;
        ack_q   <= 1'b1;
        dout_q  <= cur_wr ? '0 : rdata_d;
        // Word 3 is read-only; writes to it are acked and dropped.
        for (int i = 0; i < 3; i++) begin
          if (cur_wr && cur_word == 2'(i)) reg_q[i] <= cur_data;
        end
`ifdef IORESP_STATS_EN
        cnt_q   <= cnt_q + 36'd1;
`endif
      end else begin
        case (state_q)
          S_IDLE: if (start) state_q <= S_WAIT;
          S_WAIT: begin
            if (!busREQI) state_q <= S_IDLE;
            else          dly_q   <= dly_q - 2'd1;
          end
          S_ACK:  state_q <= S_HOLD;
          S_HOLD: if (!busREQI) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busACKO  = ack_q;
  assign busDATAO = dout_q;
  assign busBUSY  = state_q != S_IDLE;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: three responders (ACK_DELAY 0/1/2) on one bus,
// random transactions scored against a transaction-level model.
module tb_io_responder;

  localparam logic [17:0] BASE = 18'o200000;

  typedef struct {
    int unsigned cyc;
    logic [35:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        clken = 1'b0;
  logic        busREQI = 1'b0;
  logic        busIO = 1'b0;
  logic        busWRITE = 1'b0;
  logic [17:0] busADDRI = '0;
  logic [35:0] busDATAI = '0;
  logic [2:0]  ack;
  logic [2:0]  busy;
  logic [35:0] dout0, dout1, dout2;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned drv_cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [35:0] mreg [3][3];
  logic [35:0] mcnt [3];

  always #5 clk = ~clk;

  io_responder #(.BASE_ADDR(BASE), .ACK_DELAY(0)) u0 (
    .clk(clk), .rstN(rstN), .clken(clken), .busREQI(busREQI),
    .busIO(busIO), .busWRITE(busWRITE), .busADDRI(busADDRI),
    .busDATAI(busDATAI), .busACKO(ack[0]), .busDATAO(dout0),
    .busBUSY(busy[0])
  );
  io_responder #(.BASE_ADDR(BASE), .ACK_DELAY(1)) u1 (
    .clk(clk), .rstN(rstN), .clken(clken), .busREQI(busREQI),
    .busIO(busIO), .busWRITE(busWRITE), .busADDRI(busADDRI),
    .busDATAI(busDATAI), .busACKO(ack[1]), .busDATAO(dout1),
    .busBUSY(busy[1])
  );
  io_responder #(.BASE_ADDR(BASE), .ACK_DELAY(2)) u2 (
    .clk(clk), .rstN(rstN), .clken(clken), .busREQI(busREQI),
    .busIO(busIO), .busWRITE(busWRITE), .busADDRI(busADDRI),
    .busDATAI(busDATAI), .busACKO(ack[2]), .busDATAO(dout2),
    .busBUSY(busy[2])
  );

  task automatic check(string name, logic [35:0] act, logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] get_dout(int i);
    case (i)
      0: return dout0;
      1: return dout1;
      default: return dout2;
    endcase
  endfunction

  function automatic void qpush(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int unsigned qfront_cyc(int i);
    case (i)
      0: return q0[0].cyc;
      1: return q1[0].cyc;
      default: return q2[0].cyc;
    endcase
  endfunction

  function automatic logic [35:0] stat_word(int i);
`ifdef IORESP_STATS_EN
    return mcnt[i];
`else
    return (i < 0) ? mcnt[0] : 36'd0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = '0;
      for (int w = 0; w < 3; w++) mreg[i][w] = '0;
    end
  endfunction

  task automatic mon_one(int i);
    exp_t e;
    logic [35:0] d;
    d = get_dout(i);
    if (ack[i]) begin
      if (qsize(i) == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ack_unexpected: dut %0d cycle %0d got ack, expected none", i, cyc);
      end else begin
        e = qpop(i);
        check($sformatf("ack_cycle_d%0d", i), 36'(cyc), 36'(e.cyc));
        check($sformatf("rdata_d%0d", i), d, e.data);
      end
    end else begin
      check($sformatf("dout_idle_d%0d", i), d, 36'd0);
      if (qsize(i) != 0 && qfront_cyc(i) <= cyc) begin
        e = qpop(i);
        n_chk++;
        n_fail++;
        $display("FAIL ack_missing: dut %0d got no ack, expected at cycle %0d", i, e.cyc);
      end
    end
  endtask

  always begin
    @(posedge clk);
    if (rstN && clken) begin
      cyc++;
      #1;
      for (int i = 0; i < 3; i++) mon_one(i);
    end
  end

  task automatic tick();
    int g;
    g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    if (g > 0) begin
      clken = 1'b0;
      repeat (g) @(posedge clk);
      #2;
    end
    clken = 1'b1;
    @(posedge clk);
    drv_cyc++;
    #2;
  endtask

  task automatic do_txn(bit io, bit hit, bit wr, logic [1:0] w,
                        logic [35:0] data, int h);
    logic [17:0] a;
    exp_t e;
    bit sel;
    sel = io && hit;
    if (hit) a = BASE + 18'(w);
    else if ($urandom_range(0, 1) == 0) a = BASE + 18'd4 + 18'(w);
    else begin
      a = 18'($urandom);
      if ((a >> 2) == (BASE >> 2)) a = a ^ 18'h20000;
    end
    for (int i = 0; i < 3; i++) begin
      if (sel && h >= i + 1) begin
        e.cyc = drv_cyc + 1 + i;
        if (wr) e.data = '0;
        else e.data = (w == 2'd3) ? stat_word(i) : mreg[i][w];
        qpush(i, e);
        if (wr && w != 2'd3) mreg[i][w] = data;
        mcnt[i] = mcnt[i] + 36'd1;
      end
    end
    busREQI = 1'b1;
    busIO = io;
    busWRITE = wr;
    busADDRI = a;
    busDATAI = data;
    repeat (h) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("busy_held_d%0d", i), 36'(busy[i]), 36'(sel));
    busREQI = 1'b0;
    busIO = 1'($urandom);
    busWRITE = 1'($urandom);
    busADDRI = 18'($urandom);
    busDATAI = {4'($urandom), $urandom};
    tick();
    for (int i = 0; i < 3; i++) begin
      if (!(sel && h >= i + 1))
        check($sformatf("busy_idle_d%0d", i), 36'(busy[i]), 36'd0);
    end
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  task automatic rand_txns(int n);
    for (int k = 0; k < n; k++) begin
      do_txn($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
             1'($urandom), 2'($urandom), {4'($urandom), $urandom},
             ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(1, 6)));
    end
  endtask

  task automatic check_outputs_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_ack_d%0d", tag, i), 36'(ack[i]), 36'd0);
      check($sformatf("%s_dout_d%0d", tag, i), get_dout(i), 36'd0);
      check($sformatf("%s_busy_d%0d", tag, i), 36'(busy[i]), 36'd0);
    end
  endtask

  initial begin
    model_reset();
    #1 rstN = 1'b0;
    #1 check_outputs_zero("reset");
    #10 rstN = 1'b1;
    @(posedge clk);
    #2;

    do_txn(1, 1, 1, 2'd1, 36'o123456701234, 3);
    do_txn(1, 1, 0, 2'd1, '0, 3);
    do_txn(1, 0, 1, 2'd1, 36'o777000111222, 3);
    do_txn(0, 1, 1, 2'd1, 36'o555555555555, 3);
    do_txn(1, 1, 0, 2'd1, '0, 3);
    do_txn(1, 1, 0, 2'd0, '0, 10);
    do_txn(1, 1, 0, 2'd2, '0, 10);
    do_txn(1, 1, 0, 2'd3, '0, 3);
    do_txn(1, 1, 1, 2'd3, 36'o111111111111, 3);
    do_txn(1, 1, 1, 2'd2, 36'o246024602460, 2);
    do_txn(1, 1, 0, 2'd2, '0, 3);
    do_txn(1, 1, 1, 2'd0, 36'o135713571357, 1);
    do_txn(1, 1, 0, 2'd0, '0, 4);

    rand_txns(300);

    busREQI = 1'b1;
    busIO = 1'b1;
    busWRITE = 1'b1;
    busADDRI = BASE;
    busDATAI = 36'o765432107654;
    begin
      exp_t e;
      e.cyc = drv_cyc + 1;
      e.data = '0;
      qpush(0, e);
    end
    tick();
    check("wait_busy_d2", 36'(busy[2]), 36'd1);
    rstN = 1'b0;
    #1 check_outputs_zero("midreset");
    q1.delete();
    q2.delete();
    model_reset();
    busREQI = 1'b0;
    #2 rstN = 1'b1;

    do_txn(1, 1, 0, 2'd0, '0, 3);
    do_txn(1, 1, 0, 2'd3, '0, 3);
    rand_txns(60);

    repeat (4) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("drained_d%0d", i), 36'(qsize(i)), 36'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected test completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
